// File: rtl/sram_adapter_pkg.sv
// Shared types and helpers for the line-SRAM request adapter.
package sram_adapter_pkg;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned bits;
      int unsigned reach;
      bits  = 0;
      reach = 1;
      while (reach < value) begin
         reach = reach << 1;
         bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; a push into a full FIFO is taken only when a pop frees a slot.
module sram_rsp_fifo
   import sram_adapter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_push,
   input  logic [DATA_WIDTH-1:0]              i_push_data,
   input  logic                               i_pop,
   output logic [DATA_WIDTH-1:0]              o_pop_data,
   output logic                               o_full,
   output logic                               o_empty,
   output logic [clog2(DEPTH+1)-1:0]          o_count
);

   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned CW = clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_pop;
   logic                  w_push;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];
   assign w_pop      = i_pop & ~o_empty;
   assign w_push     = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/sram_line_req_adapter.sv
// Request/response front end for one line-SRAM port: init walk, read-latency tracking,
// credit-based flow control into the response FIFO.
module sram_line_req_adapter
   import sram_adapter_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH    = 128,
   parameter int unsigned             ADDRESS_WIDTH = 7,
   parameter int unsigned             READ_LATENCY  = 2,
   parameter int unsigned             RSP_DEPTH     = 4,
   parameter int unsigned             INIT_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0]   INIT_VALUE    = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_write,
   input  logic [ADDRESS_WIDTH-1:0]   i_req_address,
   input  logic [DATA_WIDTH-1:0]      i_req_write_data,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [DATA_WIDTH-1:0]      o_rsp_read_data,
   output logic                       o_init_done,
   output logic [ADDRESS_WIDTH-1:0]   o_sram_address,
   output logic [DATA_WIDTH-1:0]      o_sram_write_data,
   output logic                       o_sram_write_enable,
   input  logic [DATA_WIDTH-1:0]      i_sram_read_data
);

   localparam int unsigned              CW          = clog2(RSP_DEPTH + 1);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = '1;
   localparam state_t                   RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

   state_t                     r_state;
   logic [ADDRESS_WIDTH-1:0]   r_init_addr;
   logic                       r_init_wren;
   logic                       r_req_ready;
   logic                       r_init_done;
   logic [CW-1:0]              r_credit;
   logic [READ_LATENCY-1:0]    r_rd_pipe;

   logic                       w_req_accept;
   logic                       w_rd_accept;
   logic                       w_pop;
   logic                       w_push;
   logic [CW-1:0]              w_credit_next;
   logic                       w_fifo_full;
   logic                       w_fifo_empty;
   logic [CW-1:0]              w_fifo_count;

   assign o_req_ready   = r_req_ready;
   assign o_init_done   = r_init_done;
   assign o_rsp_valid   = ~w_fifo_empty;
   assign w_req_accept  = i_req_valid & r_req_ready;
   assign w_rd_accept   = w_req_accept & ~i_req_write;
   assign w_pop         = o_rsp_valid & i_rsp_ready;
   assign w_push        = r_rd_pipe[READ_LATENCY-1];
   // Credit covers reads still in the SRAM pipe plus FIFO entries, so a push always has room.
   assign w_credit_next = r_credit + CW'(w_rd_accept) - CW'(w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= RESET_STATE;
         r_init_addr <= '0;
         r_init_wren <= 1'b0;
         r_req_ready <= 1'b0;
         r_init_done <= 1'b0;
         r_credit    <= '0;
         r_rd_pipe   <= '0;
      end else begin
         r_credit     <= w_credit_next;
         r_rd_pipe[0] <= w_rd_accept;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
         end
         case (r_state)
            ST_INIT: begin
               r_req_ready <= 1'b0;
               if (!r_init_wren) begin
                  r_init_wren <= 1'b1;
               end else if (r_init_addr == LAST_ADDR) begin
                  r_init_wren <= 1'b0;
                  r_init_addr <= '0;
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
                  r_req_ready <= (w_credit_next < CW'(RSP_DEPTH));
               end else begin
                  r_init_addr <= r_init_addr + 1'b1;
               end
            end
            ST_RUN: begin
               r_init_done <= 1'b1;
               r_req_ready <= (w_credit_next < CW'(RSP_DEPTH));
            end
         endcase
      end
   end

   always_comb begin
      o_sram_address      = '0;
      o_sram_write_data   = '0;
      o_sram_write_enable = 1'b0;
      if (r_state == ST_INIT) begin
         if (r_init_wren) begin
            o_sram_address      = r_init_addr;
            o_sram_write_data   = INIT_VALUE;
            o_sram_write_enable = 1'b1;
         end
      end else if (w_req_accept) begin
         o_sram_address = i_req_address;
         if (i_req_write) begin
            o_sram_write_data   = i_req_write_data;
            o_sram_write_enable = 1'b1;
         end
      end
   end

   sram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_rsp_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_push_data (i_sram_read_data),
      .i_pop       (w_pop),
      .o_pop_data  (o_rsp_read_data),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         assert (!(w_push && w_fifo_full && !w_pop));
         assert (r_credit >= w_fifo_count);
      end
   end

endmodule

// File: tb/tb_sram_line_req_adapter.sv
// Bench for sram_line_req_adapter: two configurations, SRAM model, queue-based reference.
module tb_sram_line_req_adapter;

   localparam int DW    = 128;
   localparam int AW    = 4;
   localparam int DEPTH = 4;
   localparam logic [DW-1:0] INIT_V = '0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n     [2];
   logic          req_valid [2];
   logic          req_ready [2];
   logic          req_write [2];
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_data  [2];
   logic          init_done [2];
   logic [AW-1:0] s_addr    [2];
   logic [DW-1:0] s_wdata   [2];
   logic          s_wren    [2];
   logic [DW-1:0] s_rdata   [2];

   int checks = 0;
   int errors = 0;
   int outstanding [2];
   int rsp_cnt     [2];

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_data;
   } vec_t;

   function automatic logic [DW-1:0] pat(input int a);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = {4'(i), 4'(a)};
      return v;
   endfunction

   function automatic vec_t mk(input logic wr, input int addr, input logic [DW-1:0] wd,
                               input logic [DW-1:0] ed);
      vec_t v;
      v.wr = wr; v.addr = AW'(addr); v.wdata = wd; v.exp_data = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int unsigned L    = (g == 0) ? 2 : 1;
      localparam int unsigned INIT = (g == 0) ? 1 : 0;

      sram_line_req_adapter #(
         .DATA_WIDTH    (DW),
         .ADDRESS_WIDTH (AW),
         .READ_LATENCY  (L),
         .RSP_DEPTH     (DEPTH),
         .INIT_ON_RESET (INIT),
         .INIT_VALUE    (INIT_V)
      ) u_dut (
         .i_clk               (clk),
         .i_rst_n             (rst_n[g]),
         .i_req_valid         (req_valid[g]),
         .o_req_ready         (req_ready[g]),
         .i_req_write         (req_write[g]),
         .i_req_address       (req_addr[g]),
         .i_req_write_data    (req_wdata[g]),
         .o_rsp_valid         (rsp_valid[g]),
         .i_rsp_ready         (rsp_ready[g]),
         .o_rsp_read_data     (rsp_data[g]),
         .o_init_done         (init_done[g]),
         .o_sram_address      (s_addr[g]),
         .o_sram_write_data   (s_wdata[g]),
         .o_sram_write_enable (s_wren[g]),
         .i_sram_read_data    (s_rdata[g])
      );

      // SRAM port model with L cycles from address to data
      logic [DW-1:0] smem [16];
      logic [DW-1:0] rd1, rd2;
      bit            loaded = 1'b0;
      always @(posedge clk) begin
         if (!loaded) begin
            for (int a = 0; a < 16; a++) smem[a] <= pat(a);
            loaded <= 1'b1;
         end else if (s_wren[g]) begin
            smem[s_addr[g]] <= s_wdata[g];
         end
         rd1 <= smem[s_addr[g]];
         rd2 <= rd1;
      end
      assign s_rdata[g] = (L == 2) ? rd2 : rd1;

      // Reference: array memory plus queue of expected read data in accept order
      logic [DW-1:0] ref_mem [16];
      logic [DW-1:0] exp_q [$];
      bit            sb_loaded = 1'b0;
      always @(negedge clk) begin
         if (!sb_loaded) begin
            for (int a = 0; a < 16; a++) ref_mem[a] = pat(a);
            sb_loaded = 1'b1;
         end
         if (!rst_n[g]) begin
            exp_q.delete();
            if (INIT != 0) for (int a = 0; a < 16; a++) ref_mem[a] = INIT_V;
         end else begin
            chk($sformatf("ready_rule%0d", g), req_ready[g],
                init_done[g] && (exp_q.size() < DEPTH));
            if (rsp_valid[g]) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("rsp_unexpected%0d", g), rsp_valid[g], 0);
               end else begin
                  chk($sformatf("rsp_data%0d", g), rsp_data[g], exp_q[0]);
                  if (rsp_ready[g]) begin
                     void'(exp_q.pop_front());
                     rsp_cnt[g]++;
                  end
               end
            end
            if (req_valid[g] && req_ready[g]) begin
               if (req_write[g]) ref_mem[req_addr[g]] = req_wdata[g];
               else exp_q.push_back(ref_mem[req_addr[g]]);
            end
         end
         outstanding[g] = exp_q.size();
      end
   end

   task automatic reset_vals(input int s);
      chk($sformatf("rst_req_ready%0d", s), req_ready[s], 0);
      chk($sformatf("rst_rsp_valid%0d", s), rsp_valid[s], 0);
      chk($sformatf("rst_init_done%0d", s), init_done[s], 0);
      chk($sformatf("rst_wren%0d", s), s_wren[s], 0);
      chk($sformatf("rst_addr%0d", s), s_addr[s], 0);
      chk($sformatf("rst_wdata%0d", s), s_wdata[s], 0);
   endtask

   task automatic do_req(input int s, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok = 0;
      req_valid[s] = 1'b1; req_write[s] = wr; req_addr[s] = a; req_wdata[s] = d;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (req_ready[s]) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk($sformatf("req_timeout%0d", s), req_ready[s], 1);
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
   endtask

   task automatic wait_rsp(input int s, output logic [DW-1:0] d, output int n);
      bit got = 0;
      n = 0; d = '0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         n++;
         if (rsp_valid[s]) begin d = rsp_data[s]; got = 1; break; end
      end
      @(posedge clk); #1;
      if (!got) chk($sformatf("rsp_timeout%0d", s), rsp_valid[s], 1);
   endtask

   task automatic init_walk(input int s);
      int idx = 0, last = -10;
      bit found = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (init_done[s]) begin
            chk("init_count", idx, 16);
            chk("init_done_after_last", c - last, 1);
            chk("init_ready_rise", req_ready[s], 1);
            found = 1;
            break;
         end
         if (s_wren[s]) begin
            chk("init_addr", s_addr[s], idx);
            chk("init_data", s_wdata[s], INIT_V);
            idx++;
            last = c;
         end
      end
      @(posedge clk); #1;
      if (!found) chk("init_timeout", init_done[s], 1);
   endtask

   task automatic run_table(input int s);
      vec_t tbl [8];
      logic [DW-1:0] d, m9, m0;
      logic [DW-1:0] a5, ff, zz;
      int n, lat;
      lat = (s == 0) ? 3 : 2;
      m9 = (s == 0) ? INIT_V : pat(9);
      m0 = (s == 0) ? INIT_V : pat(0);
      a5 = {16{8'hA5}}; ff = {4{32'hDEADBEEF}}; zz = {4{32'h01234567}};
      tbl[0] = mk(0, 9,  '0, m9);
      tbl[1] = mk(1, 3,  a5, '0);
      tbl[2] = mk(0, 3,  '0, a5);
      tbl[3] = mk(1, 15, ff, '0);
      tbl[4] = mk(0, 15, '0, ff);
      tbl[5] = mk(0, 0,  '0, m0);
      tbl[6] = mk(1, 0,  zz, '0);
      tbl[7] = mk(0, 0,  '0, zz);
      rsp_ready[s] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_req(s, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
         if (!tbl[i].wr) begin
            wait_rsp(s, d, n);
            chk($sformatf("tbl_data%0d_%0d", s, i), d, tbl[i].exp_data);
            chk($sformatf("tbl_latency%0d_%0d", s, i), n, lat);
         end
      end
   endtask

   task automatic backpressure(input int s);
      int acc = 0, base;
      base = rsp_cnt[s];
      rsp_ready[s] = 1'b0;
      req_write[s] = 1'b0; req_addr[s] = '0; req_valid[s] = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_valid[s] && req_ready[s]) acc++;
         @(posedge clk); #1;
         if (acc >= 6) req_valid[s] = 1'b0; else req_addr[s] = AW'(acc);
      end
      chk($sformatf("bp_accepted%0d", s), acc, 4);
      @(negedge clk);
      chk($sformatf("bp_ready_low%0d", s), req_ready[s], 0);
      @(posedge clk); #1;
      rsp_ready[s] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (req_valid[s] && req_ready[s]) acc++;
         @(posedge clk); #1;
         if (acc >= 6) req_valid[s] = 1'b0; else req_addr[s] = AW'(acc);
         if (acc >= 6 && rsp_cnt[s] - base >= 6) break;
      end
      chk($sformatf("bp_total_acc%0d", s), acc, 6);
      chk($sformatf("bp_total_rsp%0d", s), rsp_cnt[s] - base, 6);
   endtask

   task automatic stream(input int s);
      int acc = 0, stall = 0, base, cyc = -1, lat;
      lat  = (s == 0) ? 2 : 1;
      base = rsp_cnt[s];
      rsp_ready[s] = 1'b1;
      req_write[s] = 1'b0; req_addr[s] = '0; req_valid[s] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (req_valid[s]) begin
            if (req_ready[s]) acc++; else stall++;
         end
         @(posedge clk); #1;
         if (acc >= 16) req_valid[s] = 1'b0; else req_addr[s] = AW'(acc);
         if (acc >= 16 && rsp_cnt[s] - base >= 16) begin cyc = c; break; end
      end
      chk($sformatf("stream_stalls%0d", s), stall, 0);
      chk($sformatf("stream_acc%0d", s), acc, 16);
      chk($sformatf("stream_rsp%0d", s), rsp_cnt[s] - base, 16);
      chk($sformatf("stream_cycles%0d", s), cyc, 16 + lat);
   endtask

   task automatic reset_tests();
      logic [DW-1:0] d;
      int n;
      bit hit = 0;
      rst_n[0] = 1'b0;
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (s_wren[0] && !init_done[0] && s_addr[0] == 4'd7) begin hit = 1; break; end
      end
      if (!hit) chk("mid_init_addr7_seen", s_addr[0], 7);
      rst_n[0] = 1'b0;
      #1 reset_vals(0);
      @(posedge clk); @(posedge clk); #1;
      rst_n[0] = 1'b1;
      init_walk(0);
      // three back-to-back reads left in pipe/FIFO when reset hits
      rsp_ready[0] = 1'b0;
      req_write[0] = 1'b0; req_addr[0] = 4'd3; req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 req_valid[0] = 1'b0;
      chk("inflight_count", outstanding[0], 3);
      rst_n[0] = 1'b0;
      #1 reset_vals(0);
      @(posedge clk); @(posedge clk); #1;
      rst_n[0] = 1'b1;
      rsp_ready[0] = 1'b1;
      init_walk(0);
      do_req(0, 1'b0, 4'd3, '0);
      wait_rsp(0, d, n);
      chk("post_reset_read3", d, INIT_V);
      chk("post_reset_latency", n, 3);
   endtask

   task automatic random_phase(input int s);
      for (int c = 0; c < 400; c++) begin
         req_valid[s] = ($urandom_range(0, 9) < 7);
         req_write[s] = ($urandom_range(0, 9) < 4);
         req_addr[s]  = AW'($urandom);
         req_wdata[s] = {$urandom, $urandom, $urandom, $urandom};
         rsp_ready[s] = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      req_valid[s] = 1'b0;
      rsp_ready[s] = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk($sformatf("drain_outstanding%0d", s), outstanding[s], 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst_n[s] = 1'b0; req_valid[s] = 1'b0; req_write[s] = 1'b0;
         req_addr[s] = '0; req_wdata[s] = '0; rsp_ready[s] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      reset_vals(0);
      reset_vals(1);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      init_walk(0);
      chk("init_done_cfg1", init_done[1], 1);
      for (int s = 0; s < 2; s++) begin
         run_table(s);
         backpressure(s);
         stream(s);
      end
      reset_tests();
      random_phase(0);
      random_phase(1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
